// File: rtl/lsu_dmem_port.sv
// lsu_dmem_port
//   Load/store unit between the execute stage and port 1 of the byte-addressable
//   32-bit data RAM. One RV32I load or store per transaction: the request is
//   checked for alignment, funct3 legality and address range, then issued to the
//   RAM as a word access with a byte-lane mask and lane-replicated store data.
//   Load data is lane-aligned and sign/zero-extended before being returned. All
//   outputs are registered.
//
// Ports
//   clk, rstf                     clock, synchronous active-high reset
//   t_req_valid/ready             core request handshake
//   t_req_we/funct3/addr/wdata    request: store flag, RV32I size/sign, byte
//                                 address, right-justified store data
//   i_rsp_valid/ready             core response handshake
//   i_rsp_data/err                extended load data (0 for stores/errors), error
//   i_mem_valid/ready             RAM request handshake
//   i_mem_we/addr/data/mask       RAM write enable, word-aligned byte address,
//                                 lane-replicated data, byte-lane write mask
//   t_mem_valid/ready/data        RAM read return (ready tied high)
module lsu_dmem_port #(
    parameter int unsigned AW = 15
) (
    input  logic          clk,
    input  logic          rstf,
    input  logic          t_req_valid,
    output logic          t_req_ready,
    input  logic          t_req_we,
    input  logic [2:0]    t_req_funct3,
    input  logic [31:0]   t_req_addr,
    input  logic [31:0]   t_req_wdata,
    output logic          i_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   i_rsp_data,
    output logic          i_rsp_err,
    output logic          i_mem_valid,
    input  logic          i_mem_ready,
    output logic          i_mem_we,
    output logic [AW-1:0] i_mem_addr,
    output logic [31:0]   i_mem_data,
    output logic [3:0]    i_mem_mask,
    input  logic          t_mem_valid,
    output logic          t_mem_ready,
    input  logic [31:0]   t_mem_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        req_err;
    logic        bad_f3;
    logic        misal;
    logic        out_of_range;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] rd_shift;
    logic [31:0] ld_data;

    assign t_mem_ready = 1'b1;

    // Request legality and store lane generation, evaluated on the live request
    // so the accept edge can register everything in one step.
    always_comb begin
        bad_f3 = t_req_we ? (t_req_funct3 > 3'd2)
                          : (t_req_funct3 == 3'd3 || t_req_funct3 == 3'd6 ||
                             t_req_funct3 == 3'd7);
        misal  = ((t_req_funct3[1:0] == 2'd1) && t_req_addr[0]) ||
                 ((t_req_funct3 == 3'd2) && (t_req_addr[1:0] != 2'b00));
        out_of_range = |(t_req_addr >> AW);
        req_err = bad_f3 | misal | out_of_range;

        st_mask = 4'b1111;
        st_data = t_req_wdata;
        case (t_req_funct3[1:0])
            2'd0: begin
                st_mask = 4'b0001 << t_req_addr[1:0];
                st_data = {4{t_req_wdata[7:0]}};
            end
            2'd1: begin
                st_mask = t_req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{t_req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = t_req_wdata;
            end
        endcase
    end

    // Read word alignment and extension for the captured load.
    always_comb begin
        rd_shift = t_mem_data >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd4:    ld_data = {24'h000000, rd_shift[7:0]};
            3'd1:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd5:    ld_data = {16'h0000, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            t_req_ready <= 1'b0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            i_rsp_err   <= 1'b0;
            i_mem_valid <= 1'b0;
            i_mem_we    <= 1'b0;
            i_mem_addr  <= '0;
            i_mem_data  <= '0;
            i_mem_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (t_req_valid && t_req_ready) begin
                        we_q        <= t_req_we;
                        f3_q        <= t_req_funct3;
                        off_q       <= t_req_addr[1:0];
                        t_req_ready <= 1'b0;
                        if (req_err) begin
                            state       <= RESP;
                            i_rsp_valid <= 1'b1;
                            i_rsp_err   <= 1'b1;
                            i_rsp_data  <= '0;
                        end else begin
                            state       <= ISSUE;
                            i_mem_valid <= 1'b1;
                            i_mem_we    <= t_req_we;
                            i_mem_addr  <= {t_req_addr[AW-1:2], 2'b00};
                            i_mem_mask  <= t_req_we ? st_mask : 4'b0000;
                            i_mem_data  <= t_req_we ? st_data : '0;
                        end
                    end else begin
                        // Ready rises one cycle after reset release.
                        t_req_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_mem_ready) begin
                        i_mem_valid <= 1'b0;
                        if (we_q) begin
                            state       <= RESP;
                            i_rsp_valid <= 1'b1;
                            i_rsp_err   <= 1'b0;
                            i_rsp_data  <= '0;
                        end else begin
                            state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (t_mem_valid) begin
                        state       <= RESP;
                        i_rsp_valid <= 1'b1;
                        i_rsp_err   <= 1'b0;
                        i_rsp_data  <= ld_data;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        i_rsp_valid <= 1'b0;
                        i_rsp_err   <= 1'b0;
                        i_rsp_data  <= '0;
                        t_req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed and randomized bench for lsu_dmem_port, with a byte-level reference
// memory and a behavioural RAM responder.
module tb_lsu_dmem_port;

    localparam int unsigned AW = 15;

    logic          clk = 1'b0;
    logic          rstf;
    logic          t_req_valid;
    logic          t_req_ready;
    logic          t_req_we;
    logic [2:0]    t_req_funct3;
    logic [31:0]   t_req_addr;
    logic [31:0]   t_req_wdata;
    logic          i_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   i_rsp_data;
    logic          i_rsp_err;
    logic          i_mem_valid;
    logic          i_mem_ready;
    logic          i_mem_we;
    logic [AW-1:0] i_mem_addr;
    logic [31:0]   i_mem_data;
    logic [3:0]    i_mem_mask;
    logic          t_mem_valid;
    logic          t_mem_ready;
    logic [31:0]   t_mem_data;

    int checks = 0;
    int errors = 0;

    lsu_dmem_port #(.AW(AW)) dut (
        .clk          (clk),
        .rstf         (rstf),
        .t_req_valid  (t_req_valid),
        .t_req_ready  (t_req_ready),
        .t_req_we     (t_req_we),
        .t_req_funct3 (t_req_funct3),
        .t_req_addr   (t_req_addr),
        .t_req_wdata  (t_req_wdata),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .i_rsp_data   (i_rsp_data),
        .i_rsp_err    (i_rsp_err),
        .i_mem_valid  (i_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .i_mem_we     (i_mem_we),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .i_mem_mask   (i_mem_mask),
        .t_mem_valid  (t_mem_valid),
        .t_mem_ready  (t_mem_ready),
        .t_mem_data   (t_mem_data)
    );

    always #5 clk = ~clk;

    // ---------------- RAM responder (32 words cover addresses 0..0x7F) -------
    logic [31:0] ram [0:31];
    bit          ram_init_done = 1'b0;
    int          mem_valid_cycles = 0;
    int          wr_count = 0;
    logic [3:0]  last_wmask = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) begin
        t_mem_valid <= 1'b0;
        if (!ram_init_done) begin
            for (int w = 0; w < 32; w++) ram[w] <= '0;
            ram_init_done <= 1'b1;
            t_mem_data    <= '0;
        end else begin
            if (i_mem_valid) mem_valid_cycles <= mem_valid_cycles + 1;
            if (i_mem_valid && i_mem_ready) begin
                if (i_mem_we) begin
                    for (int l = 0; l < 4; l++)
                        if (i_mem_mask[l]) ram[i_mem_addr[6:2]][8*l +: 8] <= i_mem_data[8*l +: 8];
                    wr_count   <= wr_count + 1;
                    last_wmask <= i_mem_mask;
                    last_wdata <= i_mem_data;
                end else begin
                    t_mem_valid <= 1'b1;
                    t_mem_data  <= ram[i_mem_addr[6:2]];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] refmem [0:127];

    function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit illegal, misaligned, oor;
        illegal    = we ? !(f3 == 0 || f3 == 1 || f3 == 2)
                        : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        misaligned = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
        oor        = a >= (32'd1 << AW);
        return illegal || misaligned || oor;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 0 || f3 == 4) return 1;
        if (f3 == 1 || f3 == 5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refmem[a[6:0] + 7'(i)];
        if (f3 == 0 && v[7])  v = v - 32'h100;
        if (f3 == 1 && v[15]) v = v - 32'h10000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(f3); i++) refmem[a[6:0] + 7'(i)] = wd[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction. mem_stall = cycles i_mem_ready held low while the request
    // is pending; rsp_stall = cycles i_rsp_ready held low while the response is.
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int mem_stall, input int rsp_stall,
                          output logic [31:0] rdata, output bit rerr, output int lat,
                          output int mem_acc, output bit timeout);
        int n;
        int mv0;
        logic [AW-1:0] s_addr;
        logic [31:0]   s_data;
        logic [3:0]    s_mask;
        logic          s_we;
        timeout = 1'b0;
        rdata   = '0;
        rerr    = 1'b0;
        lat     = 0;
        mem_acc = 0;
        @(negedge clk);
        t_req_valid  = 1'b1;
        t_req_we     = we;
        t_req_funct3 = f3;
        t_req_addr   = a;
        t_req_wdata  = wd;
        i_mem_ready  = (mem_stall == 0);
        i_rsp_ready  = (rsp_stall == 0);
        n = 0;
        while (!t_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!t_req_ready) begin
            timeout = 1'b1; t_req_valid = 1'b0; i_mem_ready = 1'b1; i_rsp_ready = 1'b1;
            return;
        end
        mv0 = mem_valid_cycles;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        lat = 1;
        if (mem_stall > 0) begin
            s_addr = i_mem_addr; s_data = i_mem_data; s_mask = i_mem_mask; s_we = i_mem_we;
            for (int i = 0; i < mem_stall; i++) begin
                check("mem_hold_valid", 32'(i_mem_valid), 32'd1);
                check("mem_hold_addr",  32'(i_mem_addr),  32'(s_addr));
                check("mem_hold_data",  i_mem_data,       s_data);
                check("mem_hold_mask",  32'(i_mem_mask),  32'(s_mask));
                check("mem_hold_we",    32'(i_mem_we),    32'(s_we));
                @(negedge clk);
                lat++;
            end
            i_mem_ready = 1'b1;
        end
        while (!i_rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!i_rsp_valid) begin
            timeout = 1'b1; i_rsp_ready = 1'b1;
            return;
        end
        rdata = i_rsp_data;
        rerr  = i_rsp_err;
        for (int i = 0; i < rsp_stall; i++) begin
            check("rsp_hold_valid", 32'(i_rsp_valid), 32'd1);
            check("rsp_hold_data",  i_rsp_data,       rdata);
            check("rsp_hold_err",   32'(i_rsp_err),   32'(rerr));
            check("rsp_hold_ready", 32'(t_req_ready), 32'd0);
            @(negedge clk);
        end
        i_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_drop_valid", 32'(i_rsp_valid), 32'd0);
        check("idle_ready",     32'(t_req_ready), 32'd1);
        mem_acc = mem_valid_cycles - mv0;
    endtask

    // Full transaction with checks against fixed or model-derived expectations.
    task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ms, input int rs,
                           input logic [31:0] exp_data, input bit exp_e, input int exp_lat);
        logic [31:0] d;
        bit e, to;
        int lat, acc;
        do_txn(we, f3, a, wd, ms, rs, d, e, lat, acc, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        if (!to) begin
            check({tag, "_data"}, d, exp_data);
            check({tag, "_err"}, 32'(e), 32'(exp_e));
            if (ms == 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            check({tag, "_mem_cycles"}, 32'(acc), exp_e ? 32'd0 : 32'(ms + 1));
        end
        if (!exp_e && we) ref_store(f3, a, wd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        bit we;
        logic [2:0] f3;
        logic [31:0] a, wd, ed;
        bit e;
        int ms, rs;

        for (int i = 0; i < 128; i++) refmem[i] = 8'h00;
        rstf = 1'b1; t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = '0;
        t_req_addr = '0; t_req_wdata = '0; i_rsp_ready = 1'b1; i_mem_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(t_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(i_rsp_valid), 32'd0);
        check("rst_rsp_data",  i_rsp_data,       32'd0);
        check("rst_rsp_err",   32'(i_rsp_err),   32'd0);
        check("rst_mem_valid", 32'(i_mem_valid), 32'd0);
        check("rst_mem_we",    32'(i_mem_we),    32'd0);
        check("rst_mem_mask",  32'(i_mem_mask),  32'd0);
        check("rst_mem_addr",  32'(i_mem_addr),  32'd0);
        check("rst_mem_data",  i_mem_data,       32'd0);
        check("rst_mem_ready", 32'(t_mem_ready), 32'd1);
        rstf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 32'(t_req_ready), 32'd1);

        // Preload through the DUT
        run_txn("pre_sw10", 1'b1, 3'd2, 32'h10, 32'h8899AABB, 0, 0, 32'd0, 1'b0, 2);
        run_txn("pre_sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, 0, 0, 32'd0, 1'b0, 2);

        // Load extension
        run_txn("lb13",  1'b0, 3'd0, 32'h13, '0, 0, 0, 32'hFFFFFF88, 1'b0, 3);
        run_txn("lbu13", 1'b0, 3'd4, 32'h13, '0, 0, 0, 32'h00000088, 1'b0, 3);
        run_txn("lh12",  1'b0, 3'd1, 32'h12, '0, 0, 0, 32'hFFFF8899, 1'b0, 3);
        run_txn("lhu10", 1'b0, 3'd5, 32'h10, '0, 0, 0, 32'h0000AABB, 1'b0, 3);
        run_txn("lw10",  1'b0, 3'd2, 32'h10, '0, 0, 0, 32'h8899AABB, 1'b0, 3);

        // Sub-word stores
        run_txn("sb21", 1'b1, 3'd0, 32'h21, 32'h000000CC, 0, 0, 32'd0, 1'b0, 2);
        check("sb21_mask",  32'(last_wmask), 32'h2);
        check("sb21_wdata", last_wdata,      32'hCCCCCCCC);
        run_txn("lw20a", 1'b0, 3'd2, 32'h20, '0, 0, 0, 32'h1122CC44, 1'b0, 3);
        run_txn("sh22", 1'b1, 3'd1, 32'h22, 32'h0000BEEF, 0, 0, 32'd0, 1'b0, 2);
        check("sh22_mask",  32'(last_wmask), 32'hC);
        check("sh22_wdata", last_wdata,      32'hBEEFBEEF);
        run_txn("lw20b", 1'b0, 3'd2, 32'h20, '0, 0, 0, 32'hBEEFCC44, 1'b0, 3);

        // Errors
        run_txn("err_lw12",  1'b0, 3'd2, 32'h12,       '0, 0, 0, 32'd0, 1'b1, 1);
        run_txn("err_lh11",  1'b0, 3'd1, 32'h11,       '0, 0, 0, 32'd0, 1'b1, 1);
        run_txn("err_ld_f3", 1'b0, 3'd3, 32'h10,       '0, 0, 0, 32'd0, 1'b1, 1);
        run_txn("err_st_f3", 1'b1, 3'd4, 32'h10,       32'h1, 0, 0, 32'd0, 1'b1, 1);
        run_txn("err_range", 1'b0, 3'd2, 32'h00010000, '0, 0, 0, 32'd0, 1'b1, 1);

        // RAM back-pressure on a store, core back-pressure on a load
        wc0 = wr_count;
        run_txn("sw30_stall", 1'b1, 3'd2, 32'h30, 32'hDEADBEEF, 3, 0, 32'd0, 1'b0, 2);
        check("sw30_one_write", 32'(wr_count - wc0), 32'd1);
        run_txn("lw30_rstall", 1'b0, 3'd2, 32'h30, '0, 0, 5, 32'hDEADBEEF, 1'b0, 3);

        // Reset while a load is waiting for read data
        @(negedge clk);
        t_req_valid = 1'b1; t_req_we = 1'b0; t_req_funct3 = 3'd2; t_req_addr = 32'h10;
        check("rdw_ready", 32'(t_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        check("rdw_issue", 32'(i_mem_valid), 32'd1);
        @(negedge clk);
        rstf = 1'b1;
        @(negedge clk);
        check("rdw_rst_ready",     32'(t_req_ready), 32'd0);
        check("rdw_rst_rsp_valid", 32'(i_rsp_valid), 32'd0);
        check("rdw_rst_rsp_data",  i_rsp_data,       32'd0);
        check("rdw_rst_mem_valid", 32'(i_mem_valid), 32'd0);
        check("rdw_rst_mem_addr",  32'(i_mem_addr),  32'd0);
        check("rdw_rst_mem_mask",  32'(i_mem_mask),  32'd0);
        rstf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rdw_no_rsp", 32'(i_rsp_valid), 32'd0);
        end
        run_txn("rdw_lw10", 1'b0, 3'd2, 32'h10, '0, 0, 0, 32'h8899AABB, 1'b0, 3);

        // Randomized transactions against the reference model
        for (int it = 0; it < 80; it++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom() | 32'h00008000;
            else                           a = 32'($urandom_range(0, 127));
            wd = $urandom();
            e  = exp_err(we, f3, a);
            ms = e ? 0 : int'($urandom_range(0, 2));
            rs = int'($urandom_range(0, 2));
            ed = (e || we) ? 32'd0 : ref_load(f3, a);
            run_txn("rnd", we, f3, a, wd, ms, rs, ed, e, e ? 1 : (we ? 2 : 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
